// File: rtl/bids22_pkg.sv
// Shared types and default widths for the bids22 auction datapath.
package bids22_pkg;

    localparam int AMT_W_DEF = 16;
    localparam int BAL_W_DEF = 32;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_INACTIVE = 2'b01,
        ERR_FUNDS    = 2'b10,
        ERR_INVALID  = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        LOCKED   = 2'b01,
        ACTIVE   = 2'b10,
        SETTLE   = 2'b11
    } port_state_t;

endpackage

// File: rtl/bids22_bidder_port_if.sv
// Bidder request/response handshake between one bidder and its port.
interface bids22_bidder_port_if #(
    parameter int AMT_W = 16
);
    logic             bid;
    logic             retract;
    logic [AMT_W-1:0] bidAmt;
    logic             ack;
    logic [1:0]       err;

    modport master (output bid, output retract, output bidAmt, input ack, input err);
    modport slave  (input bid, input retract, input bidAmt, output ack, output err);
endinterface

// File: rtl/bids22_bid_ledger.sv
// Combinational funds arithmetic: spendable plus held amount, affordability
// check and the balances that result from placing or releasing a bid.
module bids22_bid_ledger #(
    parameter int AMT_W = 16,
    parameter int BAL_W = 32
) (
    input  logic [BAL_W-1:0] balance,
    input  logic [AMT_W-1:0] bid_value,
    input  logic [AMT_W-1:0] bid_amt,
    output logic             funds_ok,
    output logic [BAL_W-1:0] bal_after_bid,
    output logic [BAL_W-1:0] bal_after_release,
    output logic             carry
);

    logic [BAL_W:0]   avail;
    logic [BAL_W-1:0] amt_ext;
    logic [BAL_W-1:0] hold_ext;

    assign amt_ext  = {{(BAL_W-AMT_W){1'b0}}, bid_amt};
    assign hold_ext = {{(BAL_W-AMT_W){1'b0}}, bid_value};

    // One extra bit so the sum is exact; the carry must stay clear because
    // hold and balance always come from a single loaded value.
    assign avail = {1'b0, balance} + {1'b0, hold_ext};

    assign funds_ok          = ({1'b0, amt_ext} <= avail);
    assign bal_after_release = avail[BAL_W-1:0];
    assign bal_after_bid     = avail[BAL_W-1:0] - amt_ext;
    assign carry             = avail[BAL_W];

endmodule

// File: rtl/bids22_bidder_port.sv
// Per-bidder responder: validates bid/retract requests against round state
// and balance, escrows the held bid and settles it when the round ends.
module bids22_bidder_port
    import bids22_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF,
    parameter int BAL_W = BAL_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bids22_bidder_port_if.slave  bus,
    input  logic                 load_en,
    input  logic [BAL_W-1:0]     load_data,
    input  logic                 lock,
    input  logic                 unlock,
    input  logic                 round_start,
    input  logic                 round_end,
    input  logic                 win_in,
    output logic                 win,
    output logic                 cfg_err,
    output logic [BAL_W-1:0]     balance,
    output logic                 bid_valid,
    output logic [AMT_W-1:0]     bid_value
);

    port_state_t      state, state_n;
    logic             win_hold, win_hold_n;
    logic             ack_q, ack_n;
    err_t             err_q, err_n;
    logic             win_n, cfg_err_n;
    logic [BAL_W-1:0] balance_n;
    logic             bid_valid_n;
    logic [AMT_W-1:0] bid_value_n;

    logic             funds_ok;
    logic [BAL_W-1:0] bal_after_bid;
    logic [BAL_W-1:0] bal_after_release;
    logic             carry;
    logic             req;

    bids22_bid_ledger #(
        .AMT_W(AMT_W),
        .BAL_W(BAL_W)
    ) u_ledger (
        .balance          (balance),
        .bid_value        (bid_value),
        .bid_amt          (bus.bidAmt),
        .funds_ok         (funds_ok),
        .bal_after_bid    (bal_after_bid),
        .bal_after_release(bal_after_release),
        .carry            (carry)
    );

    assign req     = bus.bid | bus.retract;
    assign bus.ack = ack_q;
    assign bus.err = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= UNLOCKED;
            win_hold  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= ERR_OK;
            win       <= 1'b0;
            cfg_err   <= 1'b0;
            balance   <= '0;
            bid_valid <= 1'b0;
            bid_value <= '0;
        end else begin
            state     <= state_n;
            win_hold  <= win_hold_n;
            ack_q     <= ack_n;
            err_q     <= err_n;
            win       <= win_n;
            cfg_err   <= cfg_err_n;
            balance   <= balance_n;
            bid_valid <= bid_valid_n;
            bid_value <= bid_value_n;
        end
    end

    // Priority inside a state: round_end, then bidder request, then control pulses.
    always_comb begin
        state_n     = state;
        win_hold_n  = win_hold;
        ack_n       = 1'b0;
        err_n       = ERR_OK;
        win_n       = 1'b0;
        cfg_err_n   = 1'b0;
        balance_n   = balance;
        bid_valid_n = bid_valid;
        bid_value_n = bid_value;

        case (state)
            UNLOCKED: begin
                if (req) begin
                    err_n = ERR_INACTIVE;
                end else begin
                    if (load_en)     balance_n = load_data;
                    if (round_start) cfg_err_n = 1'b1;
                    if (lock)        state_n   = LOCKED;
                end
            end
            LOCKED: begin
                if (req) begin
                    err_n = ERR_INACTIVE;
                end else begin
                    if (load_en) cfg_err_n = 1'b1;
                    if (round_start)  state_n = ACTIVE;
                    else if (unlock)  state_n = UNLOCKED;
                end
            end
            ACTIVE: begin
                if (round_end) begin
                    state_n    = SETTLE;
                    win_hold_n = win_in;
                    if (req) err_n = ERR_INACTIVE;
                end else if (bus.bid && bus.retract) begin
                    err_n = ERR_INVALID;
                end else if (bus.bid) begin
                    if (funds_ok) begin
                        balance_n   = bal_after_bid;
                        bid_value_n = bus.bidAmt;
                        bid_valid_n = 1'b1;
                        ack_n       = 1'b1;
                    end else begin
                        err_n = ERR_FUNDS;
                    end
                end else if (bus.retract) begin
                    if (bid_valid) begin
                        balance_n   = bal_after_release;
                        bid_valid_n = 1'b0;
                        bid_value_n = '0;
                        ack_n       = 1'b1;
                    end else begin
                        err_n = ERR_INVALID;
                    end
                end else if (load_en || lock || unlock) begin
                    cfg_err_n = 1'b1;
                end
            end
            SETTLE: begin
                if (req) err_n = ERR_INACTIVE;
                // A winning hold is consumed; anything else goes back to the bidder.
                if (win_hold && bid_valid) win_n = 1'b1;
                else                       balance_n = bal_after_release;
                bid_valid_n = 1'b0;
                bid_value_n = '0;
                win_hold_n  = 1'b0;
                state_n     = LOCKED;
            end
            default: state_n = UNLOCKED;
        endcase
    end

    carry_clear: assert property (@(posedge clk) disable iff (!reset_n) !carry);

endmodule

// File: tb/tb_bids22_bidder_port.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural funds model.
module tb_bids22_bidder_port;
    import bids22_pkg::*;

    localparam int AMT_W = 16;
    localparam int BAL_W = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             load_en, lock, unlock, round_start, round_end, win_in;
    logic [BAL_W-1:0] load_data;
    logic             win, cfg_err, bid_valid;
    logic [BAL_W-1:0] balance;
    logic [AMT_W-1:0] bid_value;

    int checks = 0;
    int failures = 0;

    bids22_bidder_port_if #(.AMT_W(AMT_W)) bus ();

    bids22_bidder_port #(.AMT_W(AMT_W), .BAL_W(BAL_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .load_en    (load_en),
        .load_data  (load_data),
        .lock       (lock),
        .unlock     (unlock),
        .round_start(round_start),
        .round_end  (round_end),
        .win_in     (win_in),
        .win        (win),
        .cfg_err    (cfg_err),
        .balance    (balance),
        .bid_valid  (bid_valid),
        .bid_value  (bid_value)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 armed, 2 bidding open, 3 settling.
    int         m_phase = 0;
    longint     m_spend = 0;
    longint     m_hold = 0;
    bit         m_held = 0;
    bit         m_winner = 0;
    bit         e_ack = 0, e_win = 0, e_cfg = 0;
    logic [1:0] e_err = 2'b00;

    task automatic model_step();
        longint funds;
        bit     req;
        req   = bus.bid || bus.retract;
        e_ack = 0; e_win = 0; e_cfg = 0; e_err = 2'd0;
        funds = m_spend + m_hold;
        if (m_phase == 0) begin
            if (req) e_err = 2'd1;
            else begin
                if (load_en) m_spend = longint'(load_data);
                if (round_start) e_cfg = 1;
                if (lock) m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (req) e_err = 2'd1;
            else begin
                if (load_en) e_cfg = 1;
                if (round_start) m_phase = 2;
                else if (unlock) m_phase = 0;
            end
        end else if (m_phase == 2) begin
            if (round_end) begin
                m_phase  = 3;
                m_winner = win_in;
                if (req) e_err = 2'd1;
            end else if (bus.bid && bus.retract) e_err = 2'd3;
            else if (bus.bid) begin
                if (longint'(bus.bidAmt) > funds) e_err = 2'd2;
                else begin
                    m_hold  = longint'(bus.bidAmt);
                    m_spend = funds - m_hold;
                    m_held  = 1;
                    e_ack   = 1;
                end
            end else if (bus.retract) begin
                if (m_held) begin
                    m_spend = funds; m_hold = 0; m_held = 0; e_ack = 1;
                end else e_err = 2'd3;
            end else if (load_en || lock || unlock) e_cfg = 1;
        end else begin
            if (req) e_err = 2'd1;
            if (m_winner && m_held) e_win = 1;
            else m_spend = funds;
            m_hold = 0; m_held = 0; m_phase = 1;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_spend = 0; m_hold = 0; m_held = 0; m_winner = 0;
            e_ack = 0; e_win = 0; e_cfg = 0; e_err = 2'd0;
        end else begin
            model_step();
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            check_output("ack", 64'(bus.ack), 64'(e_ack));
            check_output("err", 64'(bus.err), 64'(e_err));
            check_output("win", 64'(win), 64'(e_win));
            check_output("cfg_err", 64'(cfg_err), 64'(e_cfg));
            check_output("balance", 64'(balance), 64'(m_spend));
            check_output("bid_valid", 64'(bid_valid), 64'(m_held));
            check_output("bid_value", 64'(bid_value), 64'(m_hold));
        end
    end

    task automatic idle_inputs();
        bus.bid = 0; bus.retract = 0; bus.bidAmt = '0;
        load_en = 0; load_data = '0; lock = 0; unlock = 0;
        round_start = 0; round_end = 0; win_in = 0;
    endtask

    // Called just after a negedge; holds inputs across one rising edge.
    task automatic apply_stimulus(input logic b, input logic r, input logic [AMT_W-1:0] amt,
                                  input logic ld, input logic [BAL_W-1:0] ldd,
                                  input logic lk, input logic ulk, input logic rs,
                                  input logic re, input logic w);
        bus.bid = b; bus.retract = r; bus.bidAmt = amt;
        load_en = ld; load_data = ldd; lock = lk; unlock = ulk;
        round_start = rs; round_end = re; win_in = w;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_bid(input logic [AMT_W-1:0] amt);
        apply_stimulus(1, 0, amt, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_retract();
        apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_load(input logic [BAL_W-1:0] v);
        apply_stimulus(0, 0, 0, 1, v, 0, 0, 0, 0, 0);
    endtask
    task automatic do_lock();
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask
    task automatic do_unlock();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask
    task automatic do_start();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask
    task automatic do_end(input logic w);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, w);
    endtask
    task automatic do_idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic random_cycle();
        logic       b, r, ld, lk, ulk, rs, re, w;
        logic [AMT_W-1:0] amt;
        logic [BAL_W-1:0] ldd;
        int         pick;
        longint     funds;
        b = ($urandom_range(0, 99) < 30);
        r = ($urandom_range(0, 99) < 12);
        funds = m_spend + m_hold;
        if ($urandom_range(0, 3) == 0 && funds < 64'h10000) amt = AMT_W'(funds);
        else if ($urandom_range(0, 2) == 0) amt = AMT_W'($urandom_range(0, 16'h00FF));
        else amt = AMT_W'($urandom);
        ld = 0; lk = 0; ulk = 0; rs = 0;
        ldd = ($urandom_range(0, 1) == 1) ? BAL_W'($urandom_range(0, 32'h0002_0000)) : BAL_W'($urandom);
        pick = $urandom_range(0, 9);
        if (m_phase != 3) begin
            case (pick)
                0, 1: ld = 1;
                2, 3: lk = 1;
                4:    ulk = 1;
                5, 6: rs = 1;
                default: ;
            endcase
        end
        re = ($urandom_range(0, 99) < 8);
        w  = ($urandom_range(0, 1) == 1);
        apply_stimulus(b, r, amt, ld, ldd, lk, ulk, rs, re, w);
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        repeat (2) @(negedge clk);
        check_output("rst_balance", 64'(balance), 64'h0);
        check_output("rst_bid_valid", 64'(bid_valid), 64'h0);
        check_output("rst_bid_value", 64'(bid_value), 64'h0);
        check_output("rst_ack", 64'(bus.ack), 64'h0);
        check_output("rst_err", 64'(bus.err), 64'h0);
        check_output("rst_win", 64'(win), 64'h0);
        check_output("rst_cfg_err", 64'(cfg_err), 64'h0);
        reset_n = 1;

        do_load(32'h0001_0000);
        do_lock();
        do_start();
        do_bid(16'h1234);
        check_output("bid1_ack", 64'(bus.ack), 64'h1);
        check_output("bid1_balance", 64'(balance), 64'hEDCC);
        check_output("bid1_value", 64'(bid_value), 64'h1234);
        check_output("bid1_valid", 64'(bid_valid), 64'h1);
        do_bid(16'h2000);
        check_output("replace_balance", 64'(balance), 64'hE000);
        do_retract();
        check_output("retract_balance", 64'(balance), 64'h1_0000);
        check_output("retract_valid", 64'(bid_valid), 64'h0);
        do_retract();
        check_output("retract2_err", 64'(bus.err), 64'h3);
        do_end(0);
        do_idle();
        do_unlock();

        do_load(32'h100);
        do_lock();
        do_start();
        do_bid(16'hFFFF);
        check_output("funds_err", 64'(bus.err), 64'h2);
        check_output("funds_balance", 64'(balance), 64'h100);
        check_output("funds_valid", 64'(bid_valid), 64'h0);
        do_bid(16'h0100);
        check_output("exact_ack", 64'(bus.ack), 64'h1);
        check_output("exact_balance", 64'(balance), 64'h0);
        do_end(0);
        do_idle();
        do_unlock();

        do_load(32'h1000);
        do_lock();
        do_start();
        do_bid(16'h0050);
        do_end(1);
        do_idle();
        check_output("win_pulse", 64'(win), 64'h1);
        check_output("win_balance", 64'(balance), 64'hFB0);
        do_bid(16'h0001);
        check_output("locked_bid_err", 64'(bus.err), 64'h1);
        do_load(32'h9999);
        check_output("locked_load_cfg", 64'(cfg_err), 64'h1);
        check_output("locked_load_balance", 64'(balance), 64'hFB0);

        do_unlock();
        do_bid(16'h0001);
        check_output("unlocked_bid_err", 64'(bus.err), 64'h1);
        do_load(32'h1000);
        do_lock();
        do_start();
        do_bid(16'h0050);
        do_end(0);
        do_bid(16'h0010);
        check_output("settle_bid_err", 64'(bus.err), 64'h1);
        check_output("lose_win", 64'(win), 64'h0);
        check_output("lose_balance", 64'(balance), 64'h1000);

        do_start();
        apply_stimulus(1, 1, 16'h0010, 0, 0, 0, 0, 0, 0, 0);
        check_output("both_err", 64'(bus.err), 64'h3);
        do_bid(16'h0040);
        #2 reset_n = 0;
        #1;
        check_output("async_balance", 64'(balance), 64'h0);
        check_output("async_valid", 64'(bid_valid), 64'h0);
        check_output("async_value", 64'(bid_value), 64'h0);
        check_output("async_ack", 64'(bus.ack), 64'h0);
        @(negedge clk);
        reset_n = 1;
        do_bid(16'h0001);
        check_output("post_reset_err", 64'(bus.err), 64'h1);

        for (int i = 0; i < 1500; i++) random_cycle();

        do_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
